boid_state_mem: RTL and testbench

BOID_STATE_MEM -- requirements
Module: boid_state_mem

---
 rtl/boid_state_mem.sv | 188 ++++++++++++++++++
 tb/tb_boid_state_mem.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_state_mem.sv
// Boid state storage: per-boid position, velocity and accumulated velocity
// fields, filled with default values after reset, then served through a
// request/response port modelling a 2-cycle block-RAM read.
module boid_state_mem #(
  parameter int NUM_BOIDS = 2,
  parameter int IDX_W     = $clog2(NUM_BOIDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [6:0]       w_en,
  input  logic [27:0]      x_in,
  input  logic [26:0]      y_in,
  input  logic [20:0]      vx_in,
  input  logic [20:0]      vy_in,
  input  logic [31:0]      vx_acc_in,
  input  logic [31:0]      vy_acc_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [27:0]      x_out,
  output logic [26:0]      y_out,
  output logic [20:0]      vx_out,
  output logic [20:0]      vy_out,
  output logic [31:0]      vx_acc_out,
  output logic [31:0]      vy_acc_out,
  output logic             resp_err,
  output logic             init_done
);

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RD_RESP} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] fill_ctr;
  logic [IDX_W-1:0] rd_idx;
  logic             accept;
  logic [31:0]      init_pos;

  logic [27:0] x_mem      [NUM_BOIDS];
  logic [26:0] y_mem      [NUM_BOIDS];
  logic [20:0] vx_mem     [NUM_BOIDS];
  logic [20:0] vy_mem     [NUM_BOIDS];
  logic [31:0] vx_acc_mem [NUM_BOIDS];
  logic [31:0] vy_acc_mem [NUM_BOIDS];

  logic [27:0] rd_x,  x_q;
  logic [26:0] rd_y,  y_q;
  logic [20:0] rd_vx, vx_q;
  logic [20:0] rd_vy, vy_q;
  logic [31:0] rd_ax, ax_q;
  logic [31:0] rd_ay, ay_q;
  logic        err_q;

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nx;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    init_done  = 1'b1;
    case (state)
      INIT: begin
        init_done = 1'b0;
        if (fill_ctr == LAST_IDX) state_nx = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_we) state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = RD_RESP;
      RD_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  // Default position for the entry being filled: (120 + 40*i) in 16.16 fixed point
  always_comb begin
    init_pos = (32'd120 + 32'd40 * 32'(fill_ctr)) << 16;
  end

  // Storage: INIT fill, then field-masked writes to in-range entries
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BOIDS; i++) begin
      if (state == INIT) begin
        if (fill_ctr == IDX_W'(i)) begin
          x_mem[i]      <= init_pos[27:0];
          y_mem[i]      <= init_pos[26:0];
          vx_mem[i]     <= 21'(32'd5 << 16);
          vy_mem[i]     <= 21'(32'd4 << 16);
          vx_acc_mem[i] <= '0;
          vy_acc_mem[i] <= '0;
        end
      end else if (accept && req_we && w_en[0] && req_idx == IDX_W'(i)) begin
        if (w_en[1]) x_mem[i]      <= x_in;
        if (w_en[2]) y_mem[i]      <= y_in;
        if (w_en[3]) vx_mem[i]     <= vx_in;
        if (w_en[4]) vy_mem[i]     <= vy_in;
        if (w_en[5]) vx_acc_mem[i] <= vx_acc_in;
        if (w_en[6]) vy_acc_mem[i] <= vy_acc_in;
      end
    end
  end

  // Read mux; an out-of-range index matches no entry and yields zeros
  always_comb begin
    rd_x  = '0;
    rd_y  = '0;
    rd_vx = '0;
    rd_vy = '0;
    rd_ax = '0;
    rd_ay = '0;
    for (int unsigned i = 0; i < NUM_BOIDS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_x  = x_mem[i];
        rd_y  = y_mem[i];
        rd_vx = vx_mem[i];
        rd_vy = vy_mem[i];
        rd_ax = vx_acc_mem[i];
        rd_ay = vy_acc_mem[i];
      end
    end
  end

  // Fill counter, read index capture and response data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_ctr <= '0;
      rd_idx   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        INIT: if (fill_ctr != LAST_IDX) fill_ctr <= fill_ctr + 1'b1;
        IDLE: if (accept && !req_we) rd_idx <= req_idx;
        RD_WAIT: begin
          x_q   <= rd_x;
          y_q   <= rd_y;
          vx_q  <= rd_vx;
          vy_q  <= rd_vy;
          ax_q  <= rd_ax;
          ay_q  <= rd_ay;
          err_q <= (rd_idx > LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  // Response outputs are forced to zero unless a response is being presented
  always_comb begin
    x_out      = '0;
    y_out      = '0;
    vx_out     = '0;
    vy_out     = '0;
    vx_acc_out = '0;
    vy_acc_out = '0;
    resp_err   = 1'b0;
    if (resp_valid) begin
      x_out      = x_q;
      y_out      = y_q;
      vx_out     = vx_q;
      vy_out     = vy_q;
      vx_acc_out = ax_q;
      vy_acc_out = ay_q;
      resp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_boid_state_mem.sv
// Scoreboard bench for boid_state_mem: reads push the expected response,
// a monitor pops and compares on every response handshake.
module tb_boid_state_mem;

  localparam int NB = 2;
  localparam int IW = $clog2(NB) + 1;

  typedef struct packed {
    logic [27:0] x;
    logic [26:0] y;
    logic [20:0] vx;
    logic [20:0] vy;
    logic [31:0] ax;
    logic [31:0] ay;
    logic        err;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [IW-1:0] req_idx = '0;
  logic [6:0]    w_en = '0;
  logic [27:0]   x_in = '0;
  logic [26:0]   y_in = '0;
  logic [20:0]   vx_in = '0;
  logic [20:0]   vy_in = '0;
  logic [31:0]   vx_acc_in = '0;
  logic [31:0]   vy_acc_in = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [27:0]   x_out;
  logic [26:0]   y_out;
  logic [20:0]   vx_out;
  logic [20:0]   vy_out;
  logic [31:0]   vx_acc_out;
  logic [31:0]   vy_acc_out;
  logic          resp_err;
  logic          init_done;

  int unsigned tests = 0;
  int unsigned fails = 0;
  resp_t       sb[$];

  boid_state_mem #(.NUM_BOIDS(NB), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_idx(req_idx),
    .w_en(w_en), .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
    .vx_acc_in(vx_acc_in), .vy_acc_in(vy_acc_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .x_out(x_out), .y_out(y_out), .vx_out(vx_out), .vy_out(vy_out),
    .vx_acc_out(vx_acc_out), .vy_acc_out(vy_acc_out),
    .resp_err(resp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  function automatic resp_t cur();
    resp_t r;
    r.x = x_out; r.y = y_out; r.vx = vx_out; r.vy = vy_out;
    r.ax = vx_acc_out; r.ay = vy_acc_out; r.err = resp_err;
    return r;
  endfunction

  function automatic resp_t mk(input logic [27:0] x, input logic [26:0] y,
                               input logic [20:0] vx, input logic [20:0] vy,
                               input logic [31:0] ax, input logic [31:0] ay,
                               input logic err);
    resp_t r;
    r.x = x; r.y = y; r.vx = vx; r.vy = vy; r.ax = ax; r.ay = ay; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented-and-consumed response with the scoreboard
  always @(negedge clk) begin
    if (!reset && resp_valid === 1'b1 && resp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got %0h expected no response", cur());
      end else begin
        resp_t e;
        e = sb.pop_front();
        if (cur() !== e) begin
          fails++;
          $display("FAIL resp_data: got %0h expected %0h", cur(), e);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [IW-1:0] idx, input logic [6:0] wen,
                      input logic [27:0] x, input logic [26:0] y,
                      input logic [20:0] vx, input logic [20:0] vy,
                      input logic [31:0] ax, input logic [31:0] ay);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got %b expected 1", req_ready);
    end
    req_we = we; req_idx = idx; w_en = wen;
    x_in = x; y_in = y; vx_in = vx; vy_in = vy; vx_acc_in = ax; vy_acc_in = ay;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [6:0] wen,
                    input logic [27:0] x, input logic [26:0] y,
                    input logic [20:0] vx, input logic [20:0] vy,
                    input logic [31:0] ax, input logic [31:0] ay);
    send(1'b1, idx, wen, x, y, vx, vy, ax, ay);
  endtask

  task automatic rd(input logic [IW-1:0] idx, input resp_t e, input int unsigned hold);
    sb.push_back(e);
    resp_ready = (hold == 0);
    send(1'b0, idx, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    chk("rd_wait_valid", 256'(resp_valid), 256'(0));
    chk("rd_wait_zero", 256'(cur()), 256'(0));
    @(negedge clk);
    chk("rd_latency_valid", 256'(resp_valid), 256'(1));
    if (hold > 0) begin
      for (int unsigned k = 0; k < hold; k++) begin
        if (k != 0) @(negedge clk);
        chk("hold_valid", 256'(resp_valid), 256'(1));
        chk("hold_data", 256'(cur()), 256'(e));
        chk("hold_req_ready", 256'(req_ready), 256'(0));
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("back_to_idle", 256'(req_ready), 256'(1));
    resp_ready = 1'b1;
  endtask

  task automatic wait_init();
    int unsigned n;
    n = 0;
    while (init_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      chk("init_no_resp", 256'(resp_valid), 256'(0));
    end
    chk("init_cycles", 256'(n), 256'(NB));
  endtask

  localparam logic [27:0] X0 = 28'h0780000;
  localparam logic [27:0] X1 = 28'h0A00000;

  initial begin
    resp_t init0, init1, e0, e1;
    init0 = mk(X0, 27'h0780000, 21'h50000, 21'h40000, '0, '0, 1'b0);
    init1 = mk(X1, 27'h0A00000, 21'h50000, 21'h40000, '0, '0, 1'b0);

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_resp_valid", 256'(resp_valid), 256'(0));
    chk("rst_init_done", 256'(init_done), 256'(0));
    chk("rst_data", 256'(cur()), 256'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_init();

    // Default contents
    rd(1, init1, 0);
    rd(0, init0, 0);

    // Only x enabled; read immediately after the write
    wr(0, 7'b0000011, 28'h0123456, 27'h5555555, 21'h1, 21'h2, 32'h3, 32'h4);
    e0 = mk(28'h0123456, 27'h0780000, 21'h50000, 21'h40000, '0, '0, 1'b0);
    rd(0, e0, 0);

    // Field enables without global enable: no change
    wr(0, 7'b1111110, 28'hAAAAAAA, 27'h2AAAAAA, 21'h15555, 21'h0AAAA, 32'h11111111, 32'h22222222);
    rd(0, e0, 0);

    // Full-width write of all fields
    wr(1, 7'h7F, 28'hFFFFFFF, 27'h7FFFFFF, 21'h1FFFFF, 21'h100001, 32'hDEADBEEF, 32'h80000001);
    e1 = mk(28'hFFFFFFF, 27'h7FFFFFF, 21'h1FFFFF, 21'h100001, 32'hDEADBEEF, 32'h80000001, 1'b0);
    rd(1, e1, 0);

    // Out-of-range write dropped, out-of-range reads flag an error
    wr(3, 7'h7F, 28'h1111111, 27'h1111111, 21'h11111, 21'h11111, 32'h11111111, 32'h11111111);
    rd(3, mk('0, '0, '0, '0, '0, '0, 1'b1), 0);
    rd(2, mk('0, '0, '0, '0, '0, '0, 1'b1), 0);
    rd(1, e1, 0);
    rd(0, e0, 0);

    // Alternate field enables: y, vy, vy_acc only
    wr(1, 7'b1010101, 28'h0000001, 27'h0000123, 21'h00001, 21'h00ABC, 32'h1, 32'h12345678);
    e1 = mk(28'hFFFFFFF, 27'h0000123, 21'h1FFFFF, 21'h00ABC, 32'hDEADBEEF, 32'h12345678, 1'b0);
    rd(1, e1, 0);

    // Back-pressure on the response for 5 cycles
    rd(0, e0, 5);

    // Reset while the read is in RD_WAIT: response must never appear
    send(1'b0, 1, '0, '0, '0, '0, '0, '0, '0);
    #1 reset = 1'b1;
    #1;
    chk("midrd_resp_valid", 256'(resp_valid), 256'(0));
    chk("midrd_init_done", 256'(init_done), 256'(0));
    chk("midrd_req_ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    chk("midrd_held_valid", 256'(resp_valid), 256'(0));
    reset = 1'b0;
    wait_init();
    rd(0, init0, 0);
    rd(1, init1, 0);

    @(negedge clk);
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
